// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, default rates and bit-period helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int DEF_CLK_FREQ = 27_000_000;
  localparam int DEF_BAUD = 115_200;
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte stream feeding the UART transmitter
interface uart_tx_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master(output tx_data, tx_valid, input tx_ready);
  modport slave(input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter pulsing bit_done every CLKS_PER_BIT cycles
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign bit_done = cnt == LAST;
  // count 0..CLKS_PER_BIT-1, wrapping at each bit boundary and restarting on accept
  always_ff @(posedge clk) cnt <= (rst || restart || bit_done) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8-bit LSB-first UART serializer; define UART_TX_PARITY_EN to add a parity bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD = DEF_BAUD,
  parameter int STOP_BITS = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic clk,
  input  logic rst,
  uart_tx_if.slave bus,
  output logic tx
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  if (CLKS_PER_BIT < 2) begin : g_cpb_err
    $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_err
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_par_err
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end
  state_t state;
  logic [7:0] sh;
  logic [2:0] idx;
  logic bit_done;
  logic accept;
`ifdef UART_TX_PARITY_EN
  logic par;
`endif
  assign accept = bus.tx_valid && bus.tx_ready;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk(clk),
    .rst(rst),
    .restart(accept),
    .bit_done(bit_done)
  );
  // frame sequencer: each bit is launched on the edge that ends the previous one
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      bus.tx_ready <= 1'b0;
      sh <= '0;
      idx <= '0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.tx_ready <= !accept;
          if (accept) begin
            state <= START;
            tx <= 1'b0;
            sh <= bus.tx_data;
`ifdef UART_TX_PARITY_EN
            par <= ^bus.tx_data ^ 1'(PARITY_ODD);
`endif
          end
        end
        START: if (bit_done) begin
          state <= DATA;
          tx <= sh[0];
          sh <= sh >> 1;
          idx <= '0;
        end
        DATA: if (bit_done) begin
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state <= PARITY;
            tx <= par;
`else
            state <= STOP;
            tx <= 1'b1;
`endif
            idx <= '0;
          end else begin
            tx <= sh[0];
            sh <= sh >> 1;
            idx <= idx + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_done) begin
          state <= STOP;
          tx <= 1'b1;
        end
`endif
        STOP: if (bit_done) begin
          if (idx == LAST_STOP) begin
            state <= IDLE;
            bus.tx_ready <= 1'b1;
            idx <= '0;
          end else idx <= idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
